// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES definitions for the MixColumns datapath: field polynomial,
//   state/column widths, the FSM state type and the GF(2^8) xtime helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam logic [7:0]  AES_POLY    = 8'h1B;
   localparam int unsigned AES_STATE_W = 128;
   localparam int unsigned AES_COL_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } aes_fsm_e;

   // Multiply by x (i.e. by 2) in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/mix_col_unit.sv
// ---------------------------------------------------------------------------
// mix_col_unit
//   Combinational MixColumns for a single 32-bit column.
//   Row byte r of a column sits at [31-8r -: 8].
//   Optional feature macro: INV_MIXCOL_EN (adds i_inv and InvMixColumns).
// Ports
//   i_col  in  32  column a0..a3
//   i_inv  in   1  (INV_MIXCOL_EN only) 1 = InvMixColumns, 0 = MixColumns
//   o_col  out 32  column b0..b3
// ---------------------------------------------------------------------------
module mix_col_unit
   import aes_pkg::*;
(
   input  logic [AES_COL_W-1:0] i_col,
`ifdef INV_MIXCOL_EN
   input  logic                 i_inv,
`endif
   output logic [AES_COL_W-1:0] o_col
);

   logic [7:0] w_a   [4];
   logic [7:0] w_x2  [4];
   logic [7:0] w_fwd [4];
`ifdef INV_MIXCOL_EN
   logic [7:0] w_x4  [4];
   logic [7:0] w_x8  [4];
   logic [7:0] w_inv [4];
`endif

   always_comb begin
      for (int unsigned r = 0; r < 4; r++) begin
         w_a[r]  = i_col[31-8*r -: 8];
         w_x2[r] = xtime(w_a[r]);
      end
      // Row r: 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3], indices mod 4.
      for (int unsigned r = 0; r < 4; r++) begin
         w_fwd[r] = w_x2[r]
                  ^ (w_x2[(r+1)%4] ^ w_a[(r+1)%4])
                  ^ w_a[(r+2)%4]
                  ^ w_a[(r+3)%4];
      end
   end

`ifdef INV_MIXCOL_EN
   always_comb begin
      for (int unsigned r = 0; r < 4; r++) begin
         w_x4[r] = xtime(w_x2[r]);
         w_x8[r] = xtime(w_x4[r]);
      end
      // 0e = x8^x4^x2, 0b = x8^x2^x, 0d = x8^x4^x, 09 = x8^x.
      for (int unsigned r = 0; r < 4; r++) begin
         w_inv[r] = (w_x8[r]       ^ w_x4[r]       ^ w_x2[r])
                  ^ (w_x8[(r+1)%4] ^ w_x2[(r+1)%4] ^ w_a[(r+1)%4])
                  ^ (w_x8[(r+2)%4] ^ w_x4[(r+2)%4] ^ w_a[(r+2)%4])
                  ^ (w_x8[(r+3)%4] ^ w_a[(r+3)%4]);
      end
   end
`endif

   always_comb begin
      o_col = '0;
      for (int unsigned r = 0; r < 4; r++) begin
`ifdef INV_MIXCOL_EN
         o_col[31-8*r -: 8] = i_inv ? w_inv[r] : w_fwd[r];
`else
         o_col[31-8*r -: 8] = w_fwd[r];
`endif
      end
   end

endmodule

// File: rtl/aes_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// aes_mix_columns_seq
//   Iterative AES MixColumns stage with valid/ready on both sides.
//   COLS_PER_CYCLE (1, 2 or 4) columns are mixed in place per BUSY cycle,
//   giving a latency of 4/COLS_PER_CYCLE edges after the input handshake.
//   Optional feature macro: INV_MIXCOL_EN (adds inv port, InvMixColumns).
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous reset, active-low
//   in_valid   in   1    in_data holds a state block
//   in_ready   out  1    high only in IDLE
//   in_data    in   128  state; column c = [127-32c -: 32]
//   out_valid  out  1    high in DONE
//   out_ready  in   1    consumer takes the result
//   out_data   out  128  MixColumns result, same layout as in_data
//   inv        in   1    (INV_MIXCOL_EN only) latched at the input handshake
// ---------------------------------------------------------------------------
module aes_mix_columns_seq
   import aes_pkg::*;
#(
   parameter int unsigned COLS_PER_CYCLE = 1
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_data
`ifdef INV_MIXCOL_EN
   ,
   input  logic                   inv
`endif
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // Counter step truncated to 2 bits: with 4 columns per cycle the count
   // stays at 0, which is also the last (and only) BUSY position.
   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);
   localparam logic [1:0] CNT_LAST = 2'((4 - COLS_PER_CYCLE) % 4);

   aes_fsm_e                r_state;
   aes_fsm_e                w_state_nxt;
   logic [1:0]              r_col_cnt;
   logic [AES_STATE_W-1:0]  r_data;
`ifdef INV_MIXCOL_EN
   logic                    r_inv;
`endif

   logic                    w_accept;
   logic                    w_last;
   logic [AES_COL_W-1:0]    w_cols    [4];
   logic [AES_COL_W-1:0]    w_wb_cols [4];
   logic [AES_COL_W-1:0]    w_mix_in  [COLS_PER_CYCLE];
   logic [AES_COL_W-1:0]    w_mix_out [COLS_PER_CYCLE];
   logic [AES_STATE_W-1:0]  w_data_nxt;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)  w_state_nxt = ST_BUSY;
         ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
      out_data  = r_data;
   end

   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_col_cnt == CNT_LAST);

   // ---------------- column select ----------------
   always_comb begin
      for (int unsigned c = 0; c < 4; c++) begin
         w_cols[c] = r_data[127-32*c -: 32];
      end
      for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
         w_mix_in[g] = w_cols[r_col_cnt + 2'(g)];
      end
   end

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
      mix_col_unit u_mix (
         .i_col (w_mix_in[g]),
`ifdef INV_MIXCOL_EN
         .i_inv (r_inv),
`endif
         .o_col (w_mix_out[g])
      );
   end

   // ---------------- write-back ----------------
   always_comb begin
      for (int unsigned c = 0; c < 4; c++) begin
         w_wb_cols[c] = w_cols[c];
      end
      for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
         w_wb_cols[r_col_cnt + 2'(g)] = w_mix_out[g];
      end
      w_data_nxt = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         w_data_nxt[127-32*c -: 32] = w_wb_cols[c];
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_col_cnt <= '0;
         r_data    <= '0;
`ifdef INV_MIXCOL_EN
         r_inv     <= 1'b0;
`endif
      end else if (w_accept) begin
         r_col_cnt <= '0;
         r_data    <= in_data;
`ifdef INV_MIXCOL_EN
         r_inv     <= inv;
`endif
      end else if (r_state == ST_BUSY) begin
         r_data    <= w_data_nxt;
         r_col_cnt <= r_col_cnt + CNT_STEP;
      end
   end

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
module tb_aes_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tb_in_valid  [3];
   logic         tb_out_ready [3];
   logic [127:0] tb_in_data   [3];
`ifdef INV_MIXCOL_EN
   logic         tb_inv       [3];
`endif
   logic         o_in_ready   [3];
   logic         o_out_valid  [3];
   logic [127:0] o_out_data   [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aes_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(tb_in_valid[0]), .in_ready(o_in_ready[0]), .in_data(tb_in_data[0]),
      .out_valid(o_out_valid[0]), .out_ready(tb_out_ready[0]), .out_data(o_out_data[0])
`ifdef INV_MIXCOL_EN
      , .inv(tb_inv[0])
`endif
   );

   aes_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(tb_in_valid[1]), .in_ready(o_in_ready[1]), .in_data(tb_in_data[1]),
      .out_valid(o_out_valid[1]), .out_ready(tb_out_ready[1]), .out_data(o_out_data[1])
`ifdef INV_MIXCOL_EN
      , .inv(tb_inv[1])
`endif
   );

   aes_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(tb_in_valid[2]), .in_ready(o_in_ready[2]), .in_data(tb_in_data[2]),
      .out_valid(o_out_valid[2]), .out_ready(tb_out_ready[2]), .out_data(o_out_data[2])
`ifdef INV_MIXCOL_EN
      , .inv(tb_inv[2])
`endif
   );

   // ---------------- reference model ----------------
   // General GF(2^8) multiply (shift-and-add), mod 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      end
      return p;
   endfunction

   // Circulant matrix product per column: b[r] = sum_j coef[(j-r) mod 4] * a[j].
   function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit iv);
      logic [7:0]   coef [4];
      logic [127:0] res = '0;
      logic [7:0]   acc;
      if (iv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               acc = acc ^ gmul(s[127-32*c-8*j -: 8], coef[(j + 4 - r) % 4]);
            end
            res[127-32*c-8*r -: 8] = acc;
         end
      end
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- transaction driver (no checking) ----------------
   task automatic run_block(input int k, input logic [127:0] d, input bit iv,
                            output logic [127:0] res, output int lat, output bit to);
      int n;
      to  = 1'b0;
      lat = 0;
      res = '0;
      @(negedge clk);
      tb_in_data[k]  = d;
`ifdef INV_MIXCOL_EN
      tb_inv[k]      = iv;
`else
      if (iv) tb_in_data[k] = d;
`endif
      tb_in_valid[k] = 1'b1;
      n = 0;
      while (!o_in_ready[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!o_in_ready[k]) begin
         tb_in_valid[k] = 1'b0;
         to = 1'b1;
         return;
      end
      @(posedge clk);
      #1 tb_in_valid[k] = 1'b0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!o_out_valid[k] && lat < 20);
      if (!o_out_valid[k]) begin
         to = 1'b1;
         return;
      end
      res = o_out_data[k];
      tb_out_ready[k] = 1'b1;
      @(posedge clk);
      #1 tb_out_ready[k] = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (o_out_valid[k] !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", k, o_out_valid[k]);
         end
         total++;
         if (o_out_data[k] !== 128'h0) begin
            bad++; $display("FAIL reset_out_data dut%0d got=%h exp=0", k, o_out_data[k]);
         end
         total++;
         if (o_in_ready[k] !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready dut%0d got=%b exp=1", k, o_in_ready[k]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fips();
      logic [127:0] res;
      int lat;
      bit to;
      int lat_exp [3] = '{4, 2, 1};
      for (int k = 0; k < 3; k++) begin
         run_block(k, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, res, lat, to);
         total++;
         if (to) begin
            bad++; $display("FAIL fips_timeout dut%0d", k);
            continue;
         end
         if (res !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
            bad++; $display("FAIL fips_data dut%0d got=%h exp=8e4da1bc9fdc589d01010101c6c6c6c6", k, res);
         end
         total++;
         if (lat !== lat_exp[k]) begin
            bad++; $display("FAIL fips_latency dut%0d got=%0d exp=%0d", k, lat, lat_exp[k]);
         end
      end
   endtask

   task automatic test_vector2();
      logic [127:0] res;
      int lat;
      bit to;
      for (int k = 0; k < 3; k++) begin
         run_block(k, 128'hd4d4d4d5_2d26314c_00000000_00000000, 1'b0, res, lat, to);
         total++;
         if (to || res !== 128'hd5d5d7d6_4d7ebdf8_00000000_00000000) begin
            bad++; $display("FAIL vec2_data dut%0d got=%h exp=d5d5d7d64d7ebdf80000000000000000 to=%b", k, res, to);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] d;
      logic [127:0] held;
      int n;
      d = rand128();
      @(negedge clk);
      tb_in_data[0]  = d;
      tb_in_valid[0] = 1'b1;
      @(posedge clk);
      #1 tb_in_valid[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!o_out_valid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!o_out_valid[0]) begin
         bad++; $display("FAIL bp_timeout dut0 out_valid never rose");
         return;
      end
      held = o_out_data[0];
      total++;
      if (held !== ref_mix(d, 1'b0)) begin
         bad++; $display("FAIL bp_data got=%h exp=%h", held, ref_mix(d, 1'b0));
      end
      tb_in_valid[0] = 1'b1;
      tb_in_data[0]  = rand128();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (o_out_valid[0] !== 1'b1 || o_in_ready[0] !== 1'b0 || o_out_data[0] !== held) begin
            bad++;
            $display("FAIL bp_hold cyc%0d out_valid=%b in_ready=%b data=%h exp_valid=1 exp_ready=0 exp_data=%h",
                     i, o_out_valid[0], o_in_ready[0], o_out_data[0], held);
         end
      end
      tb_in_valid[0]  = 1'b0;
      tb_out_ready[0] = 1'b1;
      @(posedge clk);
      #1 tb_out_ready[0] = 1'b0;
      @(negedge clk);
      total++;
      if (o_out_valid[0] !== 1'b0 || o_in_ready[0] !== 1'b1) begin
         bad++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", o_out_valid[0], o_in_ready[0]);
      end
   endtask

   task automatic test_reset_midop();
      logic [127:0] res;
      logic [127:0] d;
      int lat;
      bit to;
      bit seen;
      @(negedge clk);
      tb_in_data[0]  = rand128();
      tb_in_valid[0] = 1'b1;
      @(posedge clk);
      #1 tb_in_valid[0] = 1'b0;
      // two more edges: column counter now at 2
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (o_out_valid[0] !== 1'b0 || o_out_data[0] !== 128'h0 || o_in_ready[0] !== 1'b1) begin
         bad++;
         $display("FAIL midrst_state out_valid=%b data=%h in_ready=%b exp 0/0/1",
                  o_out_valid[0], o_out_data[0], o_in_ready[0]);
      end
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (o_out_valid[0] !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++; $display("FAIL midrst_partial got=out_valid_seen exp=none");
      end
      d = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      run_block(0, d, 1'b0, res, lat, to);
      total++;
      if (to || res !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
         bad++; $display("FAIL midrst_recover got=%h to=%b exp=8e4da1bc9fdc589d01010101c6c6c6c6", res, to);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] vin [3];
      int idx;
      int got;
      int cyc;
      bit acc;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) vin[i] = rand128();
         idx = 0;
         got = 0;
         cyc = 0;
         tb_out_ready[k] = 1'b1;
         while (got < 3 && cyc < 100) begin
            @(negedge clk);
            tb_in_valid[k] = (idx < 3);
            if (idx < 3) tb_in_data[k] = vin[idx];
            acc = tb_in_valid[k] && o_in_ready[k];
            if (o_out_valid[k] && o_in_ready[k]) begin
               total++; bad++;
               $display("FAIL b2b_ready_in_done dut%0d got=in_ready1 exp=0", k);
            end
            if (o_out_valid[k]) begin
               total++;
               if (got >= idx || o_out_data[k] !== ref_mix(vin[got], 1'b0)) begin
                  bad++;
                  $display("FAIL b2b_data dut%0d n=%0d got=%h exp=%h", k, got, o_out_data[k], ref_mix(vin[got], 1'b0));
               end
               got++;
            end
            @(posedge clk);
            if (acc) idx++;
            cyc++;
         end
         #1;
         tb_in_valid[k]  = 1'b0;
         tb_out_ready[k] = 1'b0;
         total++;
         if (got !== 3 || idx !== 3) begin
            bad++; $display("FAIL b2b_count dut%0d results=%0d accepted=%0d exp=3/3", k, got, idx);
         end
         @(negedge clk);
         total++;
         if (o_out_valid[k] !== 1'b0 || o_in_ready[k] !== 1'b1) begin
            bad++; $display("FAIL b2b_extra dut%0d out_valid=%b in_ready=%b exp 0/1", k, o_out_valid[k], o_in_ready[k]);
         end
      end
   endtask

   task automatic test_random();
      logic [127:0] d;
      logic [127:0] res;
      int lat;
      bit to;
      bit iv;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 20; i++) begin
            d = rand128();
`ifdef INV_MIXCOL_EN
            iv = 1'($urandom_range(0, 1));
`else
            iv = 1'b0;
`endif
            run_block(k, d, iv, res, lat, to);
            total++;
            if (to || res !== ref_mix(d, iv)) begin
               bad++; $display("FAIL rand_data dut%0d n=%0d inv=%b got=%h exp=%h to=%b", k, i, iv, res, ref_mix(d, iv), to);
            end
         end
      end
   endtask

`ifdef INV_MIXCOL_EN
   task automatic test_inverse();
      logic [127:0] d;
      logic [127:0] f;
      logic [127:0] r;
      int lat;
      int lat_exp [3] = '{4, 2, 1};
      bit to;
      for (int k = 0; k < 3; k++) begin
         run_block(k, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, r, lat, to);
         total++;
         if (to || r !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
            bad++; $display("FAIL inv_vec dut%0d got=%h exp=db135345f20a225c01010101c6c6c6c6", k, r);
         end
         total++;
         if (lat !== lat_exp[k]) begin
            bad++; $display("FAIL inv_latency dut%0d got=%0d exp=%0d", k, lat, lat_exp[k]);
         end
      end
      for (int i = 0; i < 1000; i++) begin
         d = rand128();
         run_block(i % 3, d, 1'b0, f, lat, to);
         run_block(i % 3, f, 1'b1, r, lat, to);
         total++;
         if (to || r !== d) begin
            bad++; $display("FAIL inv_identity n=%0d dut%0d got=%h exp=%h", i, i % 3, r, d);
         end
      end
   endtask
`endif

   initial begin
      for (int k = 0; k < 3; k++) begin
         tb_in_valid[k]  = 1'b0;
         tb_out_ready[k] = 1'b0;
         tb_in_data[k]   = '0;
`ifdef INV_MIXCOL_EN
         tb_inv[k]       = 1'b0;
`endif
      end
      test_reset();
      test_fips();
      test_vector2();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      test_random();
`ifdef INV_MIXCOL_EN
      test_inverse();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
